// File: rtl/dmem_pkg.sv
// Shared types and address decode for the dmem_arb shared data memory.
package dmem_pkg;

  localparam int BE_W           = 4;
  localparam int CORE_DEPTH_DEF = 1024;
  localparam int MBOX_BASE      = CORE_DEPTH_DEF;

  // Unmapped is encoded as zero so a cleared region flop reads back as 0.
  typedef enum logic [1:0] {
    REG_UNMAPPED = 2'd0,
    REG_CORE     = 2'd1,
    REG_MBOX     = 2'd2
  } region_t;

  typedef struct packed {
    region_t     region;
    logic [2:0]  ch;
    logic [15:0] offset;
  } decode_t;

  function automatic decode_t decode_addr(input logic [31:0] addr,
                                          input int unsigned base,
                                          input int unsigned mbox_words,
                                          input int unsigned num_ch);
    decode_t     d;
    logic [31:0] rel;
    d.region = REG_UNMAPPED;
    d.ch     = '0;
    d.offset = '0;
    rel      = '0;
    if (addr < base) begin
      d.region = REG_CORE;
    end else if (addr < base + mbox_words * num_ch) begin
      rel      = addr - base;
      d.region = REG_MBOX;
      d.ch     = 3'(rel / mbox_words);
      d.offset = 16'(rel % mbox_words);
    end
    return d;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Round-robin arbiter for the protocol channels; the core inhibits all grants.
module dmem_rr_arb #(
  parameter  int NUM_CH = 2,
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              core_clk,
  input  logic              nrst,
  input  logic              core_en,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [PTR_W-1:0]    rr_ptr;
  logic [2*NUM_CH-1:0] req_rot;
  int                  pick;

  // Rotate the request vector so bit 0 is the channel at rr_ptr.
  always_comb begin
    req_rot = {req, req} >> rr_ptr;
    gnt_any = 1'b0;
    pick    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_any && req_rot[i]) begin
        gnt_any = 1'b1;
        pick    = int'(rr_ptr) + i;
      end
    end
    if (pick >= NUM_CH) pick = pick - NUM_CH;
    if (core_en || !nrst) gnt_any = 1'b0;
    gnt_idx = PTR_W'(pick);
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = gnt_any && (gnt_idx == PTR_W'(i));
    end
  end

  always_ff @(posedge core_clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Shared data memory: core RAM plus per-channel mailboxes behind one access port.
// Define DMEM_CON_CORE_WR_EN to let channels write core RAM (read-only otherwise).
module dmem_arb
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int CORE_DEPTH = CORE_DEPTH_DEF,
  parameter int MBOX_WORDS = 16,
  parameter int NUM_CH     = 2
) (
  input  logic                   core_clk,
  input  logic                   nrst,
  input  logic                   core_en,
  input  logic [BE_W-1:0]        dm_write,
  input  logic [ADDR_W-1:0]      exe_data_addr,
  input  logic [31:0]            data_in,
  output logic [31:0]            data_out,
  input  logic [NUM_CH-1:0]      con_req,
  input  logic [BE_W*NUM_CH-1:0] con_write,
  input  logic [ADDR_W*NUM_CH-1:0] con_addr,
  input  logic [32*NUM_CH-1:0]   con_in,
  output logic [NUM_CH-1:0]      con_gnt,
  output logic [NUM_CH-1:0]      con_rvalid,
  output logic [31:0]            con_out,
  output logic [NUM_CH-1:0]      mbox_irq
);

  localparam int TOTAL    = CORE_DEPTH + NUM_CH * MBOX_WORDS;
  localparam int IDX_W    = $clog2(TOTAL);
  localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] LAST_OFF = 16'(MBOX_WORDS - 1);
`ifdef DMEM_CON_CORE_WR_EN
  localparam bit CON_CORE_WR = 1'b1;
`else
  localparam bit CON_CORE_WR = 1'b0;
`endif

  logic [31:0]       mem [TOTAL];
  logic [31:0]       rd_q;
  region_t           core_sel_q;
  logic [NUM_CH-1:0] mbox_full;

  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              chan_acc, acc_wr, core_rd, chan_rd, wr_ok;
  logic [ADDR_W-1:0] acc_addr;
  logic [BE_W-1:0]   acc_be;
  logic [31:0]       acc_wdata;
  logic [IDX_W-1:0]  mem_idx;
  decode_t           dec;

  dmem_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .core_clk (core_clk),
    .nrst     (nrst),
    .core_en  (core_en),
    .req      (con_req),
    .gnt      (con_gnt),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // Single access port: the core wins, otherwise the granted channel drives it.
  always_comb begin
    chan_acc  = gnt_any;
    acc_addr  = exe_data_addr;
    acc_be    = dm_write;
    acc_wdata = data_in;
    if (chan_acc) begin
      acc_addr  = con_addr[gnt_idx*ADDR_W +: ADDR_W];
      acc_be    = con_write[gnt_idx*BE_W +: BE_W];
      acc_wdata = con_in[gnt_idx*32 +: 32];
    end
    mem_idx = IDX_W'(acc_addr);
    dec     = decode_addr(32'(acc_addr), CORE_DEPTH, MBOX_WORDS, NUM_CH);
    acc_wr  = (core_en || chan_acc) && (|acc_be);
    core_rd = core_en && !(|acc_be);
    chan_rd = chan_acc && !(|acc_be);
    if (core_en) wr_ok = (dec.region == REG_CORE);
    else         wr_ok = (dec.region == REG_MBOX) || (CON_CORE_WR && dec.region == REG_CORE);
  end

  always_ff @(posedge core_clk) begin
    if (acc_wr && wr_ok) begin
      for (int b = 0; b < BE_W; b++) begin
        if (acc_be[b]) mem[mem_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
    if (core_rd) rd_q <= mem[mem_idx];
  end

  // A reset during a channel read drops the pending rvalid and read data.
  always_ff @(posedge core_clk or negedge nrst) begin
    if (!nrst) begin
      core_sel_q <= REG_UNMAPPED;
      con_out    <= '0;
      con_rvalid <= '0;
      mbox_full  <= '0;
    end else begin
      if (core_rd) core_sel_q <= dec.region;
      con_rvalid <= chan_rd ? con_gnt : '0;
      if (chan_rd) con_out <= (dec.region != REG_UNMAPPED) ? mem[mem_idx] : '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (dec.region == REG_MBOX && dec.ch == 3'(ch) && dec.offset == LAST_OFF) begin
          if (chan_acc && acc_wr) mbox_full[ch] <= 1'b1;
          else if (core_rd)       mbox_full[ch] <= 1'b0;
        end
      end
    end
  end

  assign data_out = (core_sel_q != REG_UNMAPPED) ? rd_q : '0;
  assign mbox_irq = mbox_full;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed vector bench for dmem_arb with two channels and default geometry.
module tb_dmem_arb;

  logic        core_clk;
  logic        nrst;
  logic        core_en;
  logic [3:0]  dm_write;
  logic [10:0] exe_data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [1:0]  con_req;
  logic [7:0]  con_write;
  logic [21:0] con_addr;
  logic [63:0] con_in;
  logic [1:0]  con_gnt;
  logic [1:0]  con_rvalid;
  logic [31:0] con_out;
  logic [1:0]  mbox_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    bit          ce;
    logic [3:0]  be;
    logic [10:0] addr;
    logic [31:0] din;
    logic [1:0]  req;
    logic [7:0]  cwr;
    logic [21:0] caddr;
    logic [63:0] cin;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    bit          chk_d;
    logic [31:0] exp_d;
    bit          chk_c;
    logic [31:0] exp_c;
    logic [1:0]  exp_irq;
  } vec_t;

  vec_t vecs[$];

  dmem_arb dut (
    .core_clk      (core_clk),
    .nrst          (nrst),
    .core_en       (core_en),
    .dm_write      (dm_write),
    .exe_data_addr (exe_data_addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .con_req       (con_req),
    .con_write     (con_write),
    .con_addr      (con_addr),
    .con_in        (con_in),
    .con_gnt       (con_gnt),
    .con_rvalid    (con_rvalid),
    .con_out       (con_out),
    .mbox_irq      (mbox_irq)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  function automatic vec_t mk(string nm, bit ce, logic [3:0] be, logic [10:0] a, logic [31:0] d,
                              logic [1:0] rq, logic [7:0] cw, logic [10:0] ca0, logic [10:0] ca1,
                              logic [31:0] ci0, logic [31:0] ci1, logic [1:0] eg, logic [1:0] erv,
                              bit cd, logic [31:0] ed, bit cc, logic [31:0] ec, logic [1:0] ei);
    vec_t v;
    v.nm = nm; v.ce = ce; v.be = be; v.addr = a; v.din = d;
    v.req = rq; v.cwr = cw; v.caddr = {ca1, ca0}; v.cin = {ci1, ci0};
    v.exp_gnt = eg; v.exp_rv = erv; v.chk_d = cd; v.exp_d = ed;
    v.chk_c = cc; v.exp_c = ec; v.exp_irq = ei;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    core_en       = v.ce;
    dm_write      = v.be;
    exe_data_addr = v.addr;
    data_in       = v.din;
    con_req       = v.req;
    con_write     = v.cwr;
    con_addr      = v.caddr;
    con_in        = v.cin;
  endtask

  // One vector per clock: grant checked before the edge, registered outputs after it.
  task automatic applyStimulus(input vec_t v);
    drive(v);
    #1;
    checkOutput({v.nm, " gnt"}, 32'(con_gnt), 32'(v.exp_gnt));
    @(posedge core_clk);
    #1;
    checkOutput({v.nm, " rvalid"}, 32'(con_rvalid), 32'(v.exp_rv));
    checkOutput({v.nm, " irq"}, 32'(mbox_irq), 32'(v.exp_irq));
    if (v.chk_d) checkOutput({v.nm, " data_out"}, data_out, v.exp_d);
    if (v.chk_c) checkOutput({v.nm, " con_out"}, con_out, v.exp_c);
    @(negedge core_clk);
  endtask

  initial begin
    logic [31:0] exp_core_wr;
`ifdef DMEM_CON_CORE_WR_EN
    exp_core_wr = 32'hCAFEF00D;
`else
    exp_core_wr = 32'h55AA55AA;
`endif
    //          name        ce be    addr     din           rq    cw     ca0      ca1      ci0           ci1           eg    erv   cd ed            cc ec            irq
    vecs.push_back(mk("cwr5",   1, 4'hF, 11'h005, 32'hDEADBEEF, 2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("crd5",   1, 4'h0, 11'h005, 32'h0,        2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 1, 32'hDEADBEEF, 0, 32'h0, 2'b00));
    vecs.push_back(mk("cwrb1",  1, 4'h2, 11'h005, 32'h0000AA00, 2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("crd5b",  1, 4'h0, 11'h005, 32'h0,        2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 1, 32'hDEADAAEF, 0, 32'h0, 2'b00));
    vecs.push_back(mk("cwr6",   1, 4'hF, 11'h006, 32'h11112222, 2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("rr1",    0, 4'h0, 11'h000, 32'h0,        2'b11, 8'h00, 11'h005, 11'h006, 32'h0, 32'h0, 2'b01, 2'b01, 0, 32'h0, 1, 32'hDEADAAEF, 2'b00));
    vecs.push_back(mk("rr2",    0, 4'h0, 11'h000, 32'h0,        2'b11, 8'h00, 11'h005, 11'h006, 32'h0, 32'h0, 2'b10, 2'b10, 0, 32'h0, 1, 32'h11112222, 2'b00));
    vecs.push_back(mk("rrcore", 1, 4'h0, 11'h005, 32'h0,        2'b11, 8'h00, 11'h005, 11'h006, 32'h0, 32'h0, 2'b00, 2'b00, 1, 32'hDEADAAEF, 1, 32'h11112222, 2'b00));
    vecs.push_back(mk("rr3",    0, 4'h0, 11'h000, 32'h0,        2'b11, 8'h00, 11'h005, 11'h006, 32'h0, 32'h0, 2'b01, 2'b01, 0, 32'h0, 1, 32'hDEADAAEF, 2'b00));
    vecs.push_back(mk("rr4",    0, 4'h0, 11'h000, 32'h0,        2'b11, 8'h00, 11'h005, 11'h006, 32'h0, 32'h0, 2'b10, 2'b10, 0, 32'h0, 1, 32'h11112222, 2'b00));
    vecs.push_back(mk("ch1mb",  0, 4'h0, 11'h000, 32'h0,        2'b10, 8'hF0, 11'h000, 11'h41F, 32'h0, 32'h12345678, 2'b10, 2'b00, 0, 32'h0, 1, 32'h11112222, 2'b10));
    vecs.push_back(mk("crdmb",  1, 4'h0, 11'h41F, 32'h0,        2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 1, 32'h12345678, 0, 32'h0, 2'b00));
    vecs.push_back(mk("cwr10",  1, 4'hF, 11'h010, 32'h55AA55AA, 2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("ch0cr",  0, 4'h0, 11'h000, 32'h0,        2'b01, 8'h0F, 11'h010, 11'h000, 32'hCAFEF00D, 32'h0, 2'b01, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("crd10",  1, 4'h0, 11'h010, 32'h0,        2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 1, exp_core_wr, 0, 32'h0, 2'b00));
    vecs.push_back(mk("crdunm", 1, 4'h0, 11'h7FF, 32'h0,        2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 1, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("ch0mb",  0, 4'h0, 11'h000, 32'h0,        2'b01, 8'h0F, 11'h400, 11'h000, 32'hA5A5A5A5, 32'h0, 2'b01, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("cwrmb",  1, 4'hF, 11'h400, 32'hFFFFFFFF, 2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("ch0rmb", 0, 4'h0, 11'h000, 32'h0,        2'b01, 8'h00, 11'h400, 11'h000, 32'h0, 32'h0, 2'b01, 2'b01, 0, 32'h0, 1, 32'hA5A5A5A5, 2'b00));
    vecs.push_back(mk("ch0x1",  0, 4'h0, 11'h000, 32'h0,        2'b01, 8'h01, 11'h41F, 11'h000, 32'h000000EE, 32'h0, 2'b01, 2'b00, 0, 32'h0, 0, 32'h0, 2'b10));
    vecs.push_back(mk("ch1rd",  0, 4'h0, 11'h000, 32'h0,        2'b10, 8'h00, 11'h000, 11'h41F, 32'h0, 32'h0, 2'b10, 2'b10, 0, 32'h0, 1, 32'h123456EE, 2'b10));
    vecs.push_back(mk("crdclr", 1, 4'h0, 11'h41F, 32'h0,        2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 1, 32'h123456EE, 0, 32'h0, 2'b00));
    vecs.push_back(mk("ch1unw", 0, 4'h0, 11'h000, 32'h0,        2'b10, 8'hF0, 11'h000, 11'h7FF, 32'h0, 32'hFFFFFFFF, 2'b10, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    vecs.push_back(mk("ch1unr", 0, 4'h0, 11'h000, 32'h0,        2'b10, 8'h00, 11'h000, 11'h7FF, 32'h0, 32'h0, 2'b10, 2'b10, 0, 32'h0, 1, 32'h0, 2'b00));
    vecs.push_back(mk("ch0rd5", 0, 4'h0, 11'h000, 32'h0,        2'b01, 8'h00, 11'h005, 11'h000, 32'h0, 32'h0, 2'b01, 2'b01, 0, 32'h0, 1, 32'hDEADAAEF, 2'b00));
    vecs.push_back(mk("ch0full",0, 4'h0, 11'h000, 32'h0,        2'b01, 8'h0F, 11'h40F, 11'h000, 32'h00000001, 32'h0, 2'b01, 2'b00, 0, 32'h0, 0, 32'h0, 2'b01));
    vecs.push_back(mk("crdpre", 1, 4'h0, 11'h005, 32'h0,        2'b00, 8'h00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 2'b00, 1, 32'hDEADAAEF, 0, 32'h0, 2'b01));

    // Power-up reset with both channels requesting: nothing may be granted.
    nrst = 1'b0;
    drive(mk("idle", 0, 4'h0, 11'h0, 32'h0, 2'b11, 8'h00, 11'h005, 11'h006, 32'h0, 32'h0, 2'b00, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    #3;
    checkOutput("reset gnt", 32'(con_gnt), 32'h0);
    checkOutput("reset rvalid", 32'(con_rvalid), 32'h0);
    checkOutput("reset data_out", data_out, 32'h0);
    checkOutput("reset con_out", con_out, 32'h0);
    checkOutput("reset irq", 32'(mbox_irq), 32'h0);
    repeat (2) @(negedge core_clk);
    nrst = 1'b1;
    con_req = 2'b00;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset arrives while ch0 read data is being returned.
    drive(mk("pre", 0, 4'h0, 11'h0, 32'h0, 2'b01, 8'h00, 11'h006, 11'h000, 32'h0, 32'h0, 2'b01, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00));
    #1;
    checkOutput("midrst gnt", 32'(con_gnt), 32'h1);
    @(posedge core_clk);
    #1;
    checkOutput("midrst pre rvalid", 32'(con_rvalid), 32'h1);
    checkOutput("midrst pre con_out", con_out, 32'h11112222);
    #1;
    con_req = 2'b11;
    con_addr = {11'h006, 11'h005};
    nrst = 1'b0;
    #1;
    checkOutput("midrst rvalid", 32'(con_rvalid), 32'h0);
    checkOutput("midrst con_out", con_out, 32'h0);
    checkOutput("midrst data_out", data_out, 32'h0);
    checkOutput("midrst irq", 32'(mbox_irq), 32'h0);
    checkOutput("midrst gnt held", 32'(con_gnt), 32'h0);
    @(negedge core_clk);
    nrst = 1'b1;
    con_req = 2'b00;
    @(posedge core_clk);
    #1;
    checkOutput("postrst rvalid", 32'(con_rvalid), 32'h0);
    @(negedge core_clk);
    applyStimulus(mk("postrst rr", 0, 4'h0, 11'h000, 32'h0, 2'b11, 8'h00, 11'h005, 11'h006, 32'h0, 32'h0, 2'b01, 2'b01, 0, 32'h0, 1, 32'hDEADAAEF, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
